// File: rtl/mfsk_pkg.sv
// Shared types and elaboration helpers for the M-ary FSK modulator.
package mfsk_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    TX   = 1'b1
  } state_t;

  function automatic int half_period(input int k, input int base_half);
    return base_half << k;
  endfunction

  // Counter must reach the longest half-period minus one; never narrower than 1 bit.
  function automatic int half_cnt_width(input int sym_bits, input int base_half);
    int w;
    w = $clog2(base_half << ((1 << sym_bits) - 1));
    return (w < 1) ? 1 : w;
  endfunction

  function automatic int sym_cnt_width(input int sym_len);
    int w;
    w = $clog2(sym_len);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/mfsk_tone_gen.sv
// Square-wave tone generator: one shared half-period counter with phase hold across reloads.
module mfsk_tone_gen #(
  parameter int CNT_W  = 5,
  parameter int HALF_W = 6
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [HALF_W-1:0] i_half,
  input  logic              i_load,
  input  logic              i_enable,
  input  logic              i_force_low,
  output logic              o_dout
);

  logic [CNT_W-1:0] r_half_cnt;
  logic             r_dout;
  logic             w_wrap;

  assign w_wrap = i_enable && ({{(HALF_W-CNT_W){1'b0}}, r_half_cnt} == (i_half - HALF_W'(1)));
  assign o_dout = r_dout;

  // A reload restarts the count but keeps the level, so the waveform stays phase-continuous.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_half_cnt <= '0;
      r_dout     <= 1'b0;
    end else if (i_force_low) begin
      r_half_cnt <= '0;
      r_dout     <= 1'b0;
    end else begin
      if (w_wrap) begin
        r_dout <= ~r_dout;
      end
      if (w_wrap || i_load) begin
        r_half_cnt <= '0;
      end else if (i_enable) begin
        r_half_cnt <= r_half_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/mfsk_modulator.sv
// M-ary FSK modulator: valid/ready symbol intake, fixed-length symbols, glitch-free tone switching.
module mfsk_modulator
  import mfsk_pkg::*;
#(
  parameter int SYM_BITS  = 2,
  parameter int BASE_HALF = 2,
  parameter int SYM_LEN   = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                din_valid,
  input  logic [SYM_BITS-1:0] din,
  output logic                din_ready,
  output logic                dout,
  output logic                sym_strobe,
  output logic                busy,
  output logic                underrun
);

  localparam int CNT_W  = half_cnt_width(SYM_BITS, BASE_HALF);
  localparam int HALF_W = CNT_W + 1;
  localparam int SYM_W  = sym_cnt_width(SYM_LEN);

  if (SYM_LEN < 2 || BASE_HALF < 1 || SYM_BITS < 1 || SYM_BITS > 4) begin : g_bad_params
    $error("mfsk_modulator: illegal parameters (SYM_LEN>=2, BASE_HALF>=1, SYM_BITS 1..4)");
  end

  state_t              r_state;
  state_t              w_next_state;
  logic [SYM_W-1:0]    r_sym_cnt;
  logic [SYM_BITS-1:0] r_cur_sym;
  logic                r_sym_strobe;
  logic                r_busy;
  logic                r_underrun;
  logic                w_last;
  logic                w_accept;
  logic                w_tone_load;
  logic                w_tone_en;
  logic                w_tone_force_low;
  logic [HALF_W-1:0]   w_half;

  assign w_last     = (r_sym_cnt == SYM_W'(SYM_LEN - 1));
  assign din_ready  = (r_state == IDLE) || ((r_state == TX) && w_last);
  assign w_accept   = din_valid && din_ready;
  assign sym_strobe = r_sym_strobe;
  assign busy       = r_busy;
  assign underrun   = r_underrun;

  always_comb begin
    w_half = HALF_W'(half_period(int'(r_cur_sym), BASE_HALF));
  end

  always_comb begin
    w_next_state     = r_state;
    w_tone_load      = 1'b0;
    w_tone_en        = 1'b0;
    w_tone_force_low = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_next_state = TX;
          w_tone_load  = 1'b1;
        end
      end
      TX: begin
        w_tone_en = 1'b1;
        if (w_last) begin
          if (w_accept) begin
            w_tone_load = 1'b1;
          end else begin
            w_next_state     = IDLE;
            w_tone_force_low = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_sym_cnt    <= '0;
      r_cur_sym    <= '0;
      r_sym_strobe <= 1'b0;
      r_busy       <= 1'b0;
      r_underrun   <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_sym_strobe <= w_accept;
      r_busy       <= (w_next_state == TX);
      r_underrun   <= (r_state == TX) && w_last && !w_accept;
      if (w_accept) begin
        r_cur_sym <= din;
      end
      if (w_accept || (w_next_state == IDLE)) begin
        r_sym_cnt <= '0;
      end else if (r_state == TX) begin
        r_sym_cnt <= r_sym_cnt + SYM_W'(1);
      end
    end
  end

  mfsk_tone_gen #(
    .CNT_W (CNT_W),
    .HALF_W(HALF_W)
  ) u_tone_gen (
    .i_clk      (clk),
    .i_rst_n    (reset),
    .i_half     (w_half),
    .i_load     (w_tone_load),
    .i_enable   (w_tone_en),
    .i_force_low(w_tone_force_low),
    .o_dout     (dout)
  );

endmodule
